// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds all channel resets, releases them in order with a
// programmable gap, flags a run timeout, and re-sequences on a filtered soft request.
module reset_sequencer #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned STAGE_GAP   = 2,
    parameter int unsigned FILTER      = 3,
    parameter int unsigned RUN_LIMIT   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              soft_req,
    output logic [CHANNELS-1:0]               rst_out,
    output logic                              ready,
    output logic [$clog2(CHANNELS+1)-1:0]     stage,
    output logic                              timeout
);

    localparam int unsigned SW = $clog2(CHANNELS + 1);
    localparam int unsigned FW = $clog2(FILTER + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    run_q, run_d;
    logic [FW-1:0]       filt_q, filt_d;
    logic [1:0]          sync_q, sync_d;
    logic [CHANNELS-1:0] rst_out_d;
    logic                ready_d;
    logic [SW-1:0]       stage_d;
    logic                timeout_d;
    logic                accept;
    logic                release_now;

    // Register stage; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            gap_q   <= '0;
            run_q   <= '0;
            filt_q  <= '0;
            sync_q  <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            stage   <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            filt_q  <= filt_d;
            sync_q  <= sync_d;
            rst_out <= rst_out_d;
            ready   <= ready_d;
            stage   <= stage_d;
            timeout <= timeout_d;
        end
    end

    // Next-state, filter and release logic.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        run_d       = run_q;
        filt_d      = filt_q;
        sync_d      = {sync_q[0], soft_req};
        rst_out_d   = rst_out;
        ready_d     = ready;
        stage_d     = stage;
        timeout_d   = timeout;
        accept      = 1'b0;
        release_now = 1'b0;

        // Filter holds at its terminal count so a held request fires only once.
        if (!sync_q[1]) begin
            filt_d = '0;
        end else if (filt_q != FW'(FILTER)) begin
            filt_d = filt_q + FW'(1);
            accept = ((filt_q + FW'(1)) == FW'(FILTER));
        end

        if (accept) begin
            state_d   = ST_ASSERT;
            hold_d    = '0;
            gap_d     = '0;
            run_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            stage_d   = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if ((hold_q + CNT_W'(1)) == CNT_W'(HOLD_CYCLES)) begin
                        hold_d      = '0;
                        release_now = 1'b1;
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if ((gap_q + CNT_W'(1)) == CNT_W'(STAGE_GAP)) begin
                        release_now = 1'b1;
                    end else begin
                        gap_d = gap_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if ((RUN_LIMIT != 0) && (run_q != CNT_W'(RUN_LIMIT))) begin
                        run_d = run_q + CNT_W'(1);
                        if ((run_q + CNT_W'(1)) == CNT_W'(RUN_LIMIT)) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase

            // Stage count doubles as the index of the next channel to release.
            if (release_now) begin
                gap_d   = '0;
                stage_d = stage + SW'(1);
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (SW'(i) == stage) begin
                        rst_out_d[i] = 1'b0;
                    end
                end
                if ((stage + SW'(1)) == SW'(CHANNELS)) begin
                    ready_d = 1'b1;
                    run_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: edge-count model checked every cycle plus directed
// literal checks for power-on, glitch, soft request, abort, async reset and sweep.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       soft_req;
    logic       soft_req2;
    logic [3:0] rst_out;
    logic       ready;
    logic [2:0] stage;
    logic       timeout;
    logic [0:0] rst_out2;
    logic       ready2;
    logic [0:0] stage2;
    logic       timeout2;

    int checks;
    int errors;
    int edge_n;
    int e1;
    int e2;
    int ones;
    logic h1, h2, synced;

    reset_sequencer #(
        .CHANNELS(4), .CNT_W(16), .HOLD_CYCLES(4), .STAGE_GAP(2), .FILTER(3), .RUN_LIMIT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_req(soft_req),
        .rst_out(rst_out), .ready(ready), .stage(stage), .timeout(timeout)
    );

    reset_sequencer #(
        .CHANNELS(1), .CNT_W(16), .HOLD_CYCLES(1), .STAGE_GAP(1), .FILTER(3), .RUN_LIMIT(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .soft_req(soft_req2),
        .rst_out(rst_out2), .ready(ready2), .stage(stage2), .timeout(timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs as a function of edges since the sequence (re)started.
    function automatic logic [3:0] exp_rst(int e, int c, int h, int g);
        logic [3:0] m;
        m = 4'b0000;
        for (int k = 0; k < c; k++) m[k] = !(e >= h + k * g);
        return m;
    endfunction

    function automatic int exp_stage(int e, int c, int h, int g);
        int n;
        n = 0;
        for (int k = 0; k < c; k++) if (e >= h + k * g) n++;
        return n;
    endfunction

    function automatic logic exp_ready(int e, int c, int h, int g);
        return e >= h + (c - 1) * g;
    endfunction

    function automatic logic exp_to(int e, int c, int h, int g, int rl);
        return (rl != 0) && (e >= h + (c - 1) * g + rl);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Model: tracks edges since restart; a request is accepted when the two-edge
    // delayed request has been high for exactly FILTER consecutive edges.
    initial begin
        e1 = 0; e2 = 0; edge_n = 0; ones = 0; h1 = 0; h2 = 0; synced = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                e1 = 0; e2 = 0; edge_n = 0; ones = 0; h1 = 0; h2 = 0;
            end else begin
                edge_n++;
                e2++;
                synced = h2;
                h2 = h1;
                h1 = soft_req;
                ones = synced ? ones + 1 : 0;
                if (ones == 3) e1 = 0;
                else e1++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("m_rst_out", 32'(rst_out), 32'(exp_rst(e1, 4, 4, 2)));
            chk("m_stage", 32'(stage), 32'(exp_stage(e1, 4, 4, 2)));
            chk("m_ready", 32'(ready), 32'(exp_ready(e1, 4, 4, 2)));
            chk("m_timeout", 32'(timeout), 32'(exp_to(e1, 4, 4, 2, 16)));
            chk("m2_rst_out", 32'(rst_out2), 32'(exp_rst(e2, 1, 1, 1) & 4'b0001));
            chk("m2_stage", 32'(stage2), 32'(exp_stage(e2, 1, 1, 1)));
            chk("m2_ready", 32'(ready2), 32'(exp_ready(e2, 1, 1, 1)));
            chk("m2_timeout", 32'(timeout2), 32'(exp_to(e2, 1, 1, 1, 0)));
        end
    end

    task automatic wait_to(input int k);
        int guard;
        guard = 0;
        while (edge_n < k && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n < k) begin
            errors++;
            $display("FAIL wait_to: edge %0d not reached (at %0d)", k, edge_n);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; soft_req = 1'b0; soft_req2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state_out", 32'(rst_out), 32'h0000000f);
        chk("rst_state_ready", 32'(ready), 32'h0);
        chk("rst_state_stage", 32'(stage), 32'h0);
        chk("rst_state_to", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // Power-on sequence
        wait_to(1);
        chk("sweep_e1_out", 32'(rst_out2), 32'h0);
        chk("sweep_e1_ready", 32'(ready2), 32'h1);
        wait_to(3);  chk("po_e3_out", 32'(rst_out), 32'h0000000f);
        wait_to(4);  chk("po_e4_out", 32'(rst_out), 32'h0000000e);
                     chk("po_e4_stage", 32'(stage), 32'h1);
        wait_to(6);  chk("po_e6_out", 32'(rst_out), 32'h0000000c);
        wait_to(9);  chk("po_e9_ready", 32'(ready), 32'h0);
        wait_to(10); chk("po_e10_out", 32'(rst_out), 32'h0);
                     chk("po_e10_ready", 32'(ready), 32'h1);
                     chk("po_e10_stage", 32'(stage), 32'h4);
        wait_to(25); chk("po_e25_to", 32'(timeout), 32'h0);
        wait_to(26); chk("po_e26_to", 32'(timeout), 32'h1);

        // Two-cycle glitch, then a held request sampled from edge 30
        soft_req = 1'b1;
        wait_to(28); soft_req = 1'b0;
        wait_to(29); soft_req = 1'b1;
        wait_to(33); chk("glitch_to", 32'(timeout), 32'h1);
                     chk("glitch_out", 32'(rst_out), 32'h0);
        wait_to(34); chk("soft_e34_out", 32'(rst_out), 32'h0000000f);
                     chk("soft_e34_to", 32'(timeout), 32'h0);
                     chk("soft_e34_ready", 32'(ready), 32'h0);
                     chk("soft_e34_stage", 32'(stage), 32'h0);
        wait_to(38); chk("soft_e38_out", 32'(rst_out), 32'h0000000e);
        wait_to(39); soft_req = 1'b0;
        wait_to(44); chk("soft_e44_out", 32'(rst_out), 32'h0);
                     chk("soft_e44_ready", 32'(ready), 32'h1);
        wait_to(59); chk("soft_e59_to", 32'(timeout), 32'h0);
        wait_to(60); chk("soft_e60_to", 32'(timeout), 32'h1);

        // Request accepted at 66, second request aborts at 74 (channel 2 slot)
        wait_to(61); soft_req = 1'b1;
        wait_to(65); soft_req = 1'b0;
        wait_to(66); chk("ab_e66_out", 32'(rst_out), 32'h0000000f);
        wait_to(69); soft_req = 1'b1;
        wait_to(73); chk("ab_e73_out", 32'(rst_out), 32'h0000000c);
                     chk("ab_e73_stage", 32'(stage), 32'h2);
                     soft_req = 1'b0;
        wait_to(74); chk("ab_e74_out", 32'(rst_out), 32'h0000000f);
                     chk("ab_e74_stage", 32'(stage), 32'h0);
        wait_to(77); chk("ab_e77_out", 32'(rst_out), 32'h0000000f);
        wait_to(78); chk("ab_e78_out", 32'(rst_out), 32'h0000000e);

        // Async reset between edges 7 and 8 of a fresh sequence
        wait_to(80);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_to(7);  chk("ar_e7_out", 32'(rst_out), 32'h0000000c);
        rst_n = 1'b0;
        #1;
        chk("ar_async_out", 32'(rst_out), 32'h0000000f);
        chk("ar_async_ready", 32'(ready), 32'h0);
        chk("ar_async_stage", 32'(stage), 32'h0);
        chk("ar_async_out2", 32'(rst_out2), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_to(1);  chk("ar_e1_ready2", 32'(ready2), 32'h1);
        wait_to(4);  chk("ar_e4_out", 32'(rst_out), 32'h0000000e);
        wait_to(10); chk("ar_e10_ready", 32'(ready), 32'h1);

        // Long run: timeout must stay clear on the RUN_LIMIT=0 instance
        repeat (1000) @(negedge clk);
        chk("sweep_to_1000", 32'(timeout2), 32'h0);
        chk("sweep_ready_1000", 32'(ready2), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer for the SOC top level, replacing hand-written single-pulse reset stimulus with a synthesizable block. It holds CHANNELS reset outputs asserted after power-on or a soft request, then releases them one at a time in fixed order, with a programmable gap between releases. A run timer flags TIMEOUT after a configurable number of cycles in the running state. A glitch-filtered soft-reset input re-runs the whole sequence.

## Interface
- CHANNELS, default 4: number of staged reset outputs; must be ≥1.
- CNT_W, default 16: width of the internal hold, gap and run counters.
- HOLD_CYCLES, default 4: edges all outputs stay asserted before channel 0 releases; must be ≥1 and < 2^CNT_W.
- STAGE_GAP, default 2: edges between successive channel releases; must be ≥1 and < 2^CNT_W.
- FILTER, default 3: consecutive synchronised-high samples that qualify SOFT_REQ; must be ≥1.
- RUN_LIMIT, default 16: edges in RUN before TIMEOUT asserts; 0 disables TIMEOUT.
- CLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- SOFT_REQ  in  1  asynchronous soft-reset request, active-high.
- RST_OUT  out  CHANNELS  active-high resets. Assertion is asynchronous on RST; release is synchronous to CLK.
- READY  out  1  high when every channel is released.
- STAGE  out  $clog2(CHANNELS+1)  number of channels currently released.
- TIMEOUT  out  1  sticky run-limit flag.

## Operation
- While RST is low: RST_OUT is all ones, READY=0, STAGE=0, TIMEOUT=0. The state is ASSERT, all counters are 0 and the synchroniser flops are 0.
- ASSERT: the hold counter increments each edge.
  - On the edge where the count reaches HOLD_CYCLES, RST_OUT[0] goes to 0, STAGE goes to 1, the gap counter clears and the state moves to RELEASE.
- RELEASE: the gap counter increments each edge.
  - At STAGE_GAP edges it releases the next channel (index = STAGE), increments STAGE and clears.
  - Channels release in order 0 to CHANNELS-1.
  - On the edge that releases the last channel, READY goes to 1 and the state moves to RUN.
  - If CHANNELS=1, READY rises on the same edge as RST_OUT[0] falls.
- RUN: the run counter increments each edge and saturates at RUN_LIMIT.
  - When the count reaches RUN_LIMIT (and RUN_LIMIT ≠ 0), TIMEOUT goes to 1 and stays there until RST or an accepted soft request.
- Soft request path:
  - SOFT_REQ passes through a 2-flop synchroniser, then a filter counter.
  - The filter counter increments while the synchronised value is 1 and clears to 0 when it is 0.
  - The request is accepted on the edge where the counter reaches FILTER.
- Acceptance is edge-qualified. After acceptance, the counter holds at FILTER until the synchronised value returns to 0. A held-high SOFT_REQ therefore triggers exactly one re-sequence.
- Accepted request, valid in any state:
  - on the same edge, RST_OUT goes to all ones, READY=0, STAGE=0 and TIMEOUT=0;
  - the hold, gap and run counters clear and the state moves to ASSERT.
  - This aborts any in-flight ASSERT or RELEASE and restarts the hold count from 0.
- If acceptance and a scheduled release fall on the same edge, acceptance wins and no channel releases.
- Counters never wrap: hold and gap clear on their terminal count, and the run counter saturates.

## Timing
Edge numbering: edge 1 is the first rising CLK after RST deasserts.
- RST_OUT[k] falls at edge HOLD_CYCLES + k·STAGE_GAP.
- READY rises and STAGE = CHANNELS at edge HOLD_CYCLES + (CHANNELS-1)·STAGE_GAP.
- TIMEOUT rises RUN_LIMIT edges after READY rises.
- Soft request latency: SOFT_REQ is stable high before edge n, so the synchronised value is 1 after edge n+1.
  - Acceptance, with all outputs re-asserted, happens at edge n+1+FILTER.
  - The release schedule then restarts with the accepting edge as edge 0.
- RST low at any time, including mid-RELEASE, forces every output to its reset value immediately, without waiting for CLK.

## Test plan
With defaults:
- Power-on: release RST before edge 1 → RST_OUT[0..3] falls at edges 4/6/8/10; STAGE steps 1..4; READY=1 at edge 10; TIMEOUT=1 at edge 26.
- Glitch rejection in RUN: SOFT_REQ high for 2 cycles, then low → no output change and TIMEOUT unaffected.
- Soft request in RUN: SOFT_REQ stable high before edge 30 and held for 10 cycles → all outputs asserted and TIMEOUT=0 at edge 34. Channels release at edges 38/40/42/44. Exactly one re-sequence occurs despite the held request.
- Abort mid-RELEASE: a request accepted at the edge where RST_OUT[2] would fall → RST_OUT=4'b1111 and STAGE=0 on that edge; RST_OUT[0] falls 4 edges later.
- Async reset mid-RELEASE: pull RST low between edges 7 and 8 → RST_OUT=4'b1111, READY=0, STAGE=0 before the next edge. The sequence restarts from edge 1 after release.
- Parameter sweep: CHANNELS=1, RUN_LIMIT=0, HOLD_CYCLES=1, STAGE_GAP=1 → RST_OUT[0] and READY change at edge 1; TIMEOUT stays 0 for 1000 cycles.
